// File: rtl/branch_unit.sv
// RV32I branch/jump resolution: combinational taken flag and next PC, plus a one-cycle registered copy.
// Define BRANCH_UNIT_STATS_EN to add branch/taken/jump cycle counters.
module branch_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_isBranch,
  input  logic            i_isJal,
  input  logic            i_isJalr,
  input  logic [2:0]      i_i_funct3,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_immB,
  input  logic [XLEN-1:0] i_immJ,
  input  logic [XLEN-1:0] i_immI,
  output logic            o_take,
  output logic [XLEN-1:0] o_nextPC,
  output logic            o_takeQ,
  output logic [XLEN-1:0] o_nextPCQ
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [31:0]     o_nBranch,
  output logic [31:0]     o_nTaken,
  output logic [31:0]     o_nJump
`endif
);

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

  logic            cond;
  logic            take_d;
  logic [XLEN-1:0] next_pc_d;
  logic            take_q;
  logic [XLEN-1:0] next_pc_q;

  always_comb begin
    cond = 1'b0;
    case (i_i_funct3)
      3'b000:  cond = (i_rs1 == i_rs2);
      3'b001:  cond = (i_rs1 != i_rs2);
      3'b100:  cond = ($signed(i_rs1) <  $signed(i_rs2));
      3'b101:  cond = ($signed(i_rs1) >= $signed(i_rs2));
      3'b110:  cond = (i_rs1 <  i_rs2);
      3'b111:  cond = (i_rs1 >= i_rs2);
      default: cond = 1'b0;
    endcase
  end

  // JALR outranks JAL, which outranks a conditional branch.
  always_comb begin
    take_d    = 1'b0;
    next_pc_d = i_pc + PC_STEP;
    if (i_isJalr) begin
      take_d    = 1'b1;
      next_pc_d = (i_rs1 + i_immI) & JALR_MASK;
    end else if (i_isJal) begin
      take_d    = 1'b1;
      next_pc_d = i_pc + i_immJ;
    end else if (i_isBranch) begin
      take_d = cond;
      if (cond) next_pc_d = i_pc + i_immB;
    end
  end

  assign o_take   = take_d;
  assign o_nextPC = next_pc_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      take_q    <= 1'b0;
      next_pc_q <= '0;
    end else begin
      take_q    <= take_d;
      next_pc_q <= next_pc_d;
    end
  end

  assign o_takeQ   = take_q;
  assign o_nextPCQ = next_pc_q;

`ifdef BRANCH_UNIT_STATS_EN
  logic        br_sel;
  logic [31:0] n_branch_q, n_taken_q, n_jump_q;

  assign br_sel = i_isBranch & ~i_isJal & ~i_isJalr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      n_branch_q <= '0;
      n_taken_q  <= '0;
      n_jump_q   <= '0;
    end else begin
      if (br_sel)            n_branch_q <= n_branch_q + 32'd1;
      if (br_sel && cond)    n_taken_q  <= n_taken_q + 32'd1;
      if (i_isJal | i_isJalr) n_jump_q  <= n_jump_q + 32'd1;
    end
  end

  assign o_nBranch = n_branch_q;
  assign o_nTaken  = n_taken_q;
  assign o_nJump   = n_jump_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Randomized and directed bench for branch_unit against a behavioural model.
module tb_branch_unit;

  logic        clk, rst;
  logic        is_br, is_jal, is_jalr;
  logic [2:0]  f3;
  logic [31:0] pc, rs1, rs2, imm_b, imm_j, imm_i;
  logic        take, take_q;
  logic [31:0] next_pc, next_pc_q;
`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] n_branch, n_taken, n_jump;
`endif

  int n_vec  = 0;
  int n_chk  = 0;
  int n_fail = 0;

  logic        exp_tq;
  logic [31:0] exp_pq;
  logic [31:0] m_nbr, m_ntk, m_njp;

  branch_unit #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_isBranch(is_br), .i_isJal(is_jal), .i_isJalr(is_jalr),
    .i_i_funct3(f3), .i_pc(pc), .i_rs1(rs1), .i_rs2(rs2),
    .i_immB(imm_b), .i_immJ(imm_j), .i_immI(imm_i),
    .o_take(take), .o_nextPC(next_pc),
    .o_takeQ(take_q), .o_nextPCQ(next_pc_q)
`ifdef BRANCH_UNIT_STATS_EN
    , .o_nBranch(n_branch), .o_nTaken(n_taken), .o_nJump(n_jump)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Branch condition from the ISA definition, using integer comparisons.
  function automatic logic cond_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint unsigned ua, ub;
    sa = int'(a); sb = int'(b);
    ua = longint'(a); ub = longint'(b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  // Returns {take, next_pc} for the currently driven instruction.
  function automatic logic [32:0] model();
    logic [31:0] t;
    if (is_jalr) begin
      t = rs1 + imm_i;
      t[0] = 1'b0;
      return {1'b1, t};
    end
    if (is_jal) return {1'b1, pc + imm_j};
    if (is_br && cond_of(f3, rs1, rs2)) return {1'b1, pc + imm_b};
    return {1'b0, pc + 32'd4};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_tq = 1'b0; exp_pq = 32'd0;
      m_nbr = 0; m_ntk = 0; m_njp = 0;
    end else begin
      {exp_tq, exp_pq} = model();
      if (is_jal || is_jalr) m_njp = m_njp + 1;
      else if (is_br) begin
        m_nbr = m_nbr + 1;
        if (cond_of(f3, rs1, rs2)) m_ntk = m_ntk + 1;
      end
    end
  end

  task automatic drive(input logic b, input logic j, input logic jr, input logic [2:0] f,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] c,
                       input logic [31:0] ib, input logic [31:0] ij, input logic [31:0] ii);
    @(negedge clk);
    is_br = b; is_jal = j; is_jalr = jr; f3 = f;
    pc = p; rs1 = a; rs2 = c; imm_b = ib; imm_j = ij; imm_i = ii;
    n_vec++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    is_br = 0; is_jal = 0; is_jalr = 0; f3 = 0;
    pc = 0; rs1 = 0; rs2 = 0; imm_b = 0; imm_j = 0; imm_i = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (take_q !== 1'b0 || next_pc_q !== 32'd0) begin
      n_fail++; $display("FAIL reset_regs: takeQ=%b nextPCQ=%h want 0/00000000", take_q, next_pc_q);
    end
    n_chk++;
    if (take !== 1'b0 || next_pc !== 32'd4) begin
      n_fail++; $display("FAIL reset_comb: take=%b nextPC=%h want 0/00000004", take, next_pc);
    end
`ifdef BRANCH_UNIT_STATS_EN
    n_chk++;
    if (n_branch !== 0 || n_taken !== 0 || n_jump !== 0) begin
      n_fail++; $display("FAIL reset_stats: %0d %0d %0d want 0 0 0", n_branch, n_taken, n_jump);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  fs [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd0};
    logic [2:0]  sel [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001};
    logic        et  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] ep  [6] = '{32'h1010, 32'h1004, 32'h1004, 32'h1010, 32'h1080, 32'h18};
    for (int i = 0; i < 6; i++) begin
      drive(sel[i][2], sel[i][1], sel[i][0], fs[i], 32'h1000, 32'd5, 32'd5, 32'd16, 32'd128, 32'd20);
      n_chk++;
      if (take !== et[i] || next_pc !== ep[i]) begin
        n_fail++; $display("FAIL directed_%0d: take=%b nextPC=%h want %b/%h", i, take, next_pc, et[i], ep[i]);
      end
      @(posedge clk); #1;
      n_chk++;
      if (take_q !== et[i] || next_pc_q !== ep[i]) begin
        n_fail++; $display("FAIL directed_q_%0d: takeQ=%b nextPCQ=%h want %b/%h", i, take_q, next_pc_q, et[i], ep[i]);
      end
    end
  endtask

  task automatic test_signedness();
    logic [2:0] fs [3] = '{3'd4, 3'd6, 3'd2};
    logic       et [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, fs[i], 32'h1000, 32'hFFFF_FFFF, 32'd1, 32'd16, 32'd128, 32'd20);
      n_chk++;
      if (take !== et[i] || next_pc !== (et[i] ? 32'h1010 : 32'h1004)) begin
        n_fail++; $display("FAIL signed_f3_%0d: take=%b nextPC=%h want %b", fs[i], take, next_pc, et[i]);
      end
    end
  endtask

  task automatic test_wrap_align();
    drive(0, 0, 0, 3'd0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    n_chk++;
    if (take !== 1'b0 || next_pc !== 32'd0) begin
      n_fail++; $display("FAIL wrap_seq: take=%b nextPC=%h want 0/00000000", take, next_pc);
    end
    drive(0, 1, 0, 3'd0, 32'hFFFF_FF00, 0, 0, 0, 32'h200, 0);
    n_chk++;
    if (next_pc !== 32'h100) begin
      n_fail++; $display("FAIL wrap_jal: nextPC=%h want 00000100", next_pc);
    end
    drive(1, 1, 1, 3'd0, 32'h1000, 32'h2001, 32'h2001, 32'd16, 32'd2, 32'd2);
    n_chk++;
    if (take !== 1'b1 || next_pc !== 32'h2002) begin
      n_fail++; $display("FAIL jalr_prio_align: take=%b nextPC=%h want 1/00002002", take, next_pc);
    end
    drive(1, 1, 0, 3'd0, 32'h1000, 32'd5, 32'd5, 32'd16, 32'd2, 32'd0);
    n_chk++;
    if (take !== 1'b1 || next_pc !== 32'h1002) begin
      n_fail++; $display("FAIL jal_prio_align: take=%b nextPC=%h want 1/00001002", take, next_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            3'($urandom_range(0, 7)), $urandom, a,
            ($urandom_range(0, 3) == 0) ? a : $urandom, $urandom, $urandom, $urandom);
      e = model();
      n_chk++;
      if ({take, next_pc} !== e) begin
        n_fail++; $display("FAIL rand_comb_%0d: take=%b nextPC=%h want %b/%h", i, take, next_pc, e[32], e[31:0]);
      end
      @(posedge clk); #1;
      n_chk++;
      if (take_q !== exp_tq || next_pc_q !== exp_pq) begin
        n_fail++; $display("FAIL rand_reg_%0d: takeQ=%b nextPCQ=%h want %b/%h", i, take_q, next_pc_q, exp_tq, exp_pq);
      end
    end
  endtask

`ifdef BRANCH_UNIT_STATS_EN
  task automatic test_stats();
    n_chk++;
    if (n_branch !== m_nbr || n_taken !== m_ntk || n_jump !== m_njp) begin
      n_fail++; $display("FAIL stats: br=%0d tk=%0d jp=%0d want %0d %0d %0d",
                         n_branch, n_taken, n_jump, m_nbr, m_ntk, m_njp);
    end
  endtask
`endif

  task automatic test_registered();
    drive(0, 1, 0, 3'd0, 32'h1000, 32'd5, 32'd5, 32'd16, 32'd128, 32'd20);
    @(posedge clk); #1;
    n_chk++;
    if (take_q !== 1'b1 || next_pc_q !== 32'h1080) begin
      n_fail++; $display("FAIL reg_jal: takeQ=%b nextPCQ=%h want 1/00001080", take_q, next_pc_q);
    end
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (take_q !== 1'b0 || next_pc_q !== 32'd0) begin
      n_fail++; $display("FAIL reg_async_rst: takeQ=%b nextPCQ=%h want 0/00000000", take_q, next_pc_q);
    end
    n_chk++;
    if (take !== 1'b1 || next_pc !== 32'h1080) begin
      n_fail++; $display("FAIL comb_in_rst: take=%b nextPC=%h want 1/00001080", take, next_pc);
    end
    @(posedge clk); #1;
    n_chk++;
    if (take_q !== 1'b0 || next_pc_q !== 32'd0) begin
      n_fail++; $display("FAIL reg_hold_rst: takeQ=%b nextPCQ=%h want 0/00000000", take_q, next_pc_q);
    end
`ifdef BRANCH_UNIT_STATS_EN
    n_chk++;
    if (n_branch !== 0 || n_taken !== 0 || n_jump !== 0) begin
      n_fail++; $display("FAIL stats_rst: %0d %0d %0d want 0 0 0", n_branch, n_taken, n_jump);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 3'd0, 32'h1000, 32'd5, 32'd5, 32'd16, 32'd128, 32'd20);
    @(posedge clk); #1;
    n_chk++;
    if (take_q !== 1'b1 || next_pc_q !== 32'h1010) begin
      n_fail++; $display("FAIL reg_after_rst: takeQ=%b nextPCQ=%h want 1/00001010", take_q, next_pc_q);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_signedness();
    test_wrap_align();
    test_back_to_back();
`ifdef BRANCH_UNIT_STATS_EN
    test_stats();
`endif
    test_registered();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
